aes_sbox_arbiter: RTL and testbench



---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sbox.sv | 9 +
 rtl/aes_subword.sv | 14 +
 rtl/aes_sbox_arbiter.sv | 79 +++++++
 tb/tb_aes_sbox_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, arbiter owner encoding and GF(2^8) S-box arithmetic.
package aes_pkg;
  localparam int AES_WORD_W = 32;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W = 8;
  localparam int AES_WORD_BYTES = AES_WORD_W / AES_BYTE_W;
  localparam int AES_WORDS = AES_STATE_W / AES_WORD_W;
  localparam logic OWN_KS = 1'b1;
  localparam logic OWN_DP = 1'b0;
  typedef logic [1:0] word_idx_t;
  typedef logic [AES_WORDS-1:0][AES_WORD_W-1:0] state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a2 = gf_mul(a, a);
    a3 = gf_mul(a2, a);
    a6 = gf_mul(a3, a3);
    a12 = gf_mul(a6, a6);
    a15 = gf_mul(a12, a3);
    a30 = gf_mul(a15, a15);
    a60 = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: single combinational AES forward S-box.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] a_i,
  output logic [AES_BYTE_W-1:0] s_o
);
  assign s_o = sbox(a_i);
endmodule

// File: rtl/aes_subword.sv
// aes_subword: four S-boxes applied bytewise to one 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] w_i,
  output logic [AES_WORD_W-1:0] w_o
);
  for (genvar g = 0; g < AES_WORD_BYTES; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i(w_i[AES_BYTE_W*g +: AES_BYTE_W]),
      .s_o(w_o[AES_BYTE_W*g +: AES_BYTE_W])
    );
  end
endmodule

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: one 32-bit S-box bank shared round-robin between key-schedule
// SubWord requests and four-slot datapath SubBytes transforms.
module aes_sbox_arbiter
  import aes_pkg::*;
#(
  parameter bit KS_PRIO_RST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ks_req_i,
  input  logic [AES_WORD_W-1:0]  ks_word_i,
  output logic                   ks_ack_o,
  output logic [AES_WORD_W-1:0]  ks_result_o,
  input  logic                   dp_start_i,
  input  logic [AES_STATE_W-1:0] dp_state_i,
  output logic                   dp_busy_o,
  output logic                   dp_done_o,
  output logic [AES_STATE_W-1:0] dp_result_o
);
  logic ks_ack_q, ks_ack_d, dp_busy_q, dp_busy_d, dp_done_q, dp_done_d, tok_q, tok_d;
  logic [AES_WORD_W-1:0] ks_result_q, ks_result_d, bank_in, bank_out;
  state_t dbuf_q, dbuf_d, dp_result_q, dp_result_d;
  word_idx_t word_idx_q, word_idx_d;
  logic ks_elig, dp_elig, grant_ks, grant_dp, last, start;

  aes_subword u_bank (
    .w_i(bank_in),
    .w_o(bank_out)
  );

  // word w sits in the packed slot AES_WORDS-1-w, which is ~w for a 2-bit index
  always_comb begin
    ks_elig = ks_req_i && !ks_ack_q;
    dp_elig = dp_busy_q && !dp_done_q;
    grant_ks = ks_elig && (!dp_elig || tok_q == OWN_KS);
    grant_dp = dp_elig && !grant_ks;
    last = grant_dp && word_idx_q == word_idx_t'(AES_WORDS - 1);
    start = !dp_busy_q && dp_start_i;
    bank_in = grant_ks ? ks_word_i : dbuf_q[~word_idx_q];
    tok_d = (ks_elig && dp_elig) ? (tok_q == OWN_KS ? OWN_DP : OWN_KS) : tok_q;
    ks_ack_d = grant_ks;
    ks_result_d = grant_ks ? bank_out : ks_result_q;
    dbuf_d = dbuf_q;
    if (grant_dp) dbuf_d[~word_idx_q] = bank_out;
    dp_result_d = last ? dbuf_d : dp_result_q;
    dp_done_d = last;
    dp_busy_d = start || (dp_busy_q && !last);
    word_idx_d = start ? '0 : grant_dp ? word_idx_q + 2'd1 : word_idx_q;
    if (start) dbuf_d = dp_state_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_ack_q <= 1'b0;
      ks_result_q <= '0;
      dp_busy_q <= 1'b0;
      dp_done_q <= 1'b0;
      dp_result_q <= '0;
      dbuf_q <= '0;
      word_idx_q <= '0;
      tok_q <= KS_PRIO_RST;
    end else begin
      ks_ack_q <= ks_ack_d;
      ks_result_q <= ks_result_d;
      dp_busy_q <= dp_busy_d;
      dp_done_q <= dp_done_d;
      dp_result_q <= dp_result_d;
      dbuf_q <= dbuf_d;
      word_idx_q <= word_idx_d;
      tok_q <= tok_d;
    end
  end

  assign ks_ack_o = ks_ack_q;
  assign ks_result_o = ks_result_q;
  assign dp_busy_o = dp_busy_q;
  assign dp_done_o = dp_done_q;
  assign dp_result_o = dp_result_q;
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb_aes_sbox_arbiter: two arbiters (token reset 1 and 0) checked every cycle against
// a slot-level reference model with a brute-force S-box table.
module tb_aes_sbox_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ks_req[2], ks_ack[2], dp_start[2], dp_busy[2], dp_done[2];
  logic [31:0] ks_word[2], ks_result[2];
  logic [127:0] dp_state[2], dp_result[2];

  aes_sbox_arbiter #(.KS_PRIO_RST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ks_req_i(ks_req[0]), .ks_word_i(ks_word[0]),
    .ks_ack_o(ks_ack[0]), .ks_result_o(ks_result[0]), .dp_start_i(dp_start[0]),
    .dp_state_i(dp_state[0]), .dp_busy_o(dp_busy[0]), .dp_done_o(dp_done[0]),
    .dp_result_o(dp_result[0])
  );
  aes_sbox_arbiter #(.KS_PRIO_RST(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ks_req_i(ks_req[1]), .ks_word_i(ks_word[1]),
    .ks_ack_o(ks_ack[1]), .ks_result_o(ks_result[1]), .dp_start_i(dp_start[1]),
    .dp_state_i(dp_state[1]), .dp_busy_o(dp_busy[1]), .dp_done_o(dp_done[1]),
    .dp_result_o(dp_result[1])
  );

  int n_chk = 0;
  int n_err = 0;
  byte unsigned sb[256];
  bit prio[2] = '{1'b1, 1'b0};
  bit m_ack[2], m_busy[2], m_done[2], m_tok[2];
  logic [31:0] m_kres[2];
  logic [127:0] m_res[2];
  byte unsigned m_buf[2][16];
  int m_cnt[2];

  localparam logic [127:0] ST_INC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SB_INC = 128'h637c777bf26b6fc53001672bfed7ab76;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic byte unsigned gmul(input byte unsigned a, input byte unsigned b);
    int r, x;
    r = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) r = r ^ x;
      x = x << 1;
      if (x >= 256) x = x ^ 'h11b;
    end
    return r[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(byte'(x), byte'(y)) == 8'd1) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] ref_sub(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sb[w[8*k +: 8]];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ack[d] = 0; m_busy[d] = 0; m_done[d] = 0; m_tok[d] = prio[d];
      m_kres[d] = '0; m_res[d] = '0; m_cnt[d] = 0;
      for (int i = 0; i < 16; i++) m_buf[d][i] = 8'h00;
    end
  endtask

  // one clock of slot service, from the arbitration rules
  task automatic model_step(input int d);
    bit ke, de, sk, sd;
    ke = ks_req[d] && !m_ack[d];
    de = m_busy[d] && !m_done[d];
    sk = ke && (!de || m_tok[d]);
    sd = de && !sk;
    if (ke && de) m_tok[d] = !m_tok[d];
    m_ack[d] = sk;
    if (sk) m_kres[d] = ref_sub(ks_word[d]);
    m_done[d] = 0;
    if (sd) begin
      for (int k = 0; k < 4; k++) m_buf[d][4*m_cnt[d]+k] = sb[m_buf[d][4*m_cnt[d]+k]];
      m_cnt[d]++;
      if (m_cnt[d] == 4) begin
        for (int i = 0; i < 16; i++) m_res[d][127-8*i -: 8] = m_buf[d][i];
        m_done[d] = 1; m_busy[d] = 0; m_cnt[d] = 0;
      end
    end else if (!m_busy[d] && dp_start[d]) begin
      for (int i = 0; i < 16; i++) m_buf[d][i] = dp_state[d][127-8*i -: 8];
      m_busy[d] = 1; m_cnt[d] = 0;
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ks_ack%0d", d), 128'(ks_ack[d]), 128'(m_ack[d]));
      chk($sformatf("ks_result%0d", d), 128'(ks_result[d]), 128'(m_kres[d]));
      chk($sformatf("dp_busy%0d", d), 128'(dp_busy[d]), 128'(m_busy[d]));
      chk($sformatf("dp_done%0d", d), 128'(dp_done[d]), 128'(m_done[d]));
      chk($sformatf("dp_result%0d", d), dp_result[d], m_res[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_done(input int d, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dp_done[d] && n < 40);
    if (n >= 40) chk("done_timeout", 128'(n), 128'(0));
  endtask

  task automatic start_dp(input int d, input logic [127:0] st);
    dp_start[d] = 1'b1;
    dp_state[d] = st;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0;
    for (int d = 0; d < 2; d++) begin
      ks_req[d] = 0; ks_word[d] = '0; dp_start[d] = 0; dp_state[d] = '0;
    end
    build_sbox();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // SubWord vector and the mandatory ack gap
    ks_req[0] = 1; ks_word[0] = 32'hcf4f3c09;
    n = 0;
    do begin tick(); n++; end while (!ks_ack[0] && n < 5);
    chk("ks_lat", 128'(n), 128'(1));
    chk("ks_vec", 128'(ks_result[0]), 128'h8a84eb01);
    n = 0;
    do begin tick(); n++; end while (!ks_ack[0] && n < 5);
    chk("ks_gap", 128'(n), 128'(2));
    ks_req[0] = 0;
    tick();

    // uncontended SubBytes
    start_dp(0, ST_INC);
    tick();
    dp_start[0] = 0;
    wait_done(0, n);
    chk("dp_lat", 128'(n + 1), 128'(5));
    chk("dp_vec", dp_result[0], SB_INC);

    // ks held throughout a transform
    ks_req[0] = 1;
    start_dp(0, ST_INC);
    tick();
    dp_start[0] = 0;
    wait_done(0, n);
    chk("dp_lat_ks", 128'(n + 1), 128'(7));
    chk("dp_vec_ks", dp_result[0], SB_INC);
    chk("ks_vec_ks", 128'(ks_result[0]), 128'h8a84eb01);
    ks_req[0] = 0;

    // start while busy ignored, start in the done cycle accepted
    start_dp(0, ST_INC);
    tick();
    start_dp(0, {16{8'hff}});
    tick();
    dp_start[0] = 0;
    wait_done(0, n);
    chk("ignore_busy", dp_result[0], SB_INC);
    start_dp(0, {16{8'hff}});
    tick();
    dp_start[0] = 0;
    wait_done(0, n);
    chk("done_restart", dp_result[0], {16{8'h16}});

    // asynchronous reset after word 1
    start_dp(0, ST_INC);
    tick();
    dp_start[0] = 0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", 128'(ks_ack[0]), 128'(0));
    chk("rst_kres", 128'(ks_result[0]), 128'(0));
    chk("rst_busy", 128'(dp_busy[0]), 128'(0));
    chk("rst_done", 128'(dp_done[0]), 128'(0));
    chk("rst_dres", dp_result[0], 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    start_dp(0, {16{8'h53}});
    tick();
    dp_start[0] = 0;
    wait_done(0, n);
    chk("post_rst_vec", dp_result[0], {16{8'hed}});

    // token reset to datapath
    start_dp(1, ST_INC);
    tick();
    dp_start[1] = 0;
    ks_req[1] = 1; ks_word[1] = 32'hcf4f3c09;
    tick();
    chk("p0_dp_first", 128'(ks_ack[1]), 128'(0));
    tick();
    chk("p0_ks_next", 128'(ks_ack[1]), 128'(1));
    ks_req[1] = 0;
    wait_done(1, n);
    chk("p0_dp_vec", dp_result[1], SB_INC);

    // randomized traffic on both arbiters
    t0 = n_chk;
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!ks_req[d] || m_ack[d]) begin
          ks_req[d] = ($urandom_range(0, 2) != 0);
          ks_word[d] = $urandom;
        end
        dp_start[d] = ($urandom_range(0, 3) == 0);
        dp_state[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    chk("random_ran", 128'(n_chk > t0), 128'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
